mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one sequentialMultiplier instance between NREQ requesters, each with a valid/ready request port and a valid/ready response port.
- Picks one requester round-robin and latches its operands.
- Issues a one-cycle start pulse to the multiplier, waits for its done, captures the signed product, and returns it to the winning requester with a timeout/error path.
- Sits between the ALU front-end issue logic and the single shared multiplier datapath.

Parameters:
- NREQ, 4, number of requesters; 2..8 supported.
- WIDTH, 32, signed operand width; product is 2*WIDTH.
- TIMEOUT, 100, maximum cycles in BLANK+WAIT before an error response; must be >= 2.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, NREQ, per-requester request valid.
- req_ready, output, NREQ, per-requester accept; at most one bit high.
- req_a, input, NREQ*WIDTH, packed signed operand A; slice i belongs to requester i.
- req_b, input, NREQ*WIDTH, packed signed operand B.
- rsp_valid, output, NREQ, one-hot response valid to the granted requester.
- rsp_ready, input, NREQ, per-requester response accept.
- rsp_product, output, 2*WIDTH, signed product shared by all requesters; qualified by rsp_valid.
- rsp_err, output, 1, timeout flag qualified by rsp_valid.
- busy, output, 1, high in every state except IDLE.
- mult_start, output, 1, start pulse to the multiplier.
- mult_a, output, WIDTH, latched operand A to the multiplier.
- mult_b, output, WIDTH, latched operand B to the multiplier.
- mult_product, input, 2*WIDTH, multiplier product.
- mult_done, input, 1, multiplier done.
- mult_active, input, 1, multiplier active; used only for status, not for control.

Behaviour:
- Reset values, all outputs 0:
  - req_ready=0, rsp_valid=0, rsp_product=0, rsp_err=0, busy=0, mult_start=0, mult_a=0, mult_b=0.
  - State=IDLE, round-robin pointer last=NREQ-1 so requester 0 has first priority, timeout counter=0.
- States: IDLE, ISSUE, BLANK, WAIT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot bit for the winner, high only when any req_valid is high.
  - Winner is the first requester with req_valid set, searching from (last+1) mod NREQ upward with wrap.
  - On the handshake: latch the winner's A/B into mult_a/mult_b, record grant index, set last=grant, go to ISSUE.
- ISSUE: mult_start=1 for exactly this one cycle; go to BLANK.
- BLANK: one cycle in which mult_done is ignored, because done may be stale from the previous operation; go to WAIT.
- WAIT:
  - mult_done=1: capture mult_product into rsp_product, rsp_err=0, go to RESP.
  - Timeout: counter runs from BLANK entry; when TIMEOUT cycles elapse without done, rsp_product=0, rsp_err=1, go to RESP.
  - mult_start is never re-issued.
- RESP:
  - rsp_valid[grant]=1; rsp_product and rsp_err are held stable.
  - On rsp_ready[grant]=1: clear rsp_valid, go to IDLE on the next cycle.
  - rsp_ready bits of other requesters are ignored.
- Latency: request accepted at cycle T.
  - mult_start is high at T+1.
  - If mult_done is first seen at cycle D >= T+3, rsp_valid rises at D+1.
  - Minimum request-to-response is 4 cycles plus multiplier latency.
- Throughput: one operation in flight. The earliest next req_ready is the cycle after the rsp handshake.
- mult_a/mult_b hold their latched values until the next grant, so the multiplier may sample them on any cycle.
- Simultaneous requests: only the winner gets req_ready. Losers keep req_valid and operands stable, and are served in round-robin order.
  - Example: with all four requesting continuously and last=3, grant order is 0,1,2,3,0.
- A requester dropping req_valid before grant is legal and is not latched.
- mult_done high in ISSUE or BLANK is ignored.
- mult_done together with the timeout expiry in the same cycle: done wins, rsp_err=0.
- Reset mid-operation (any state): next cycle IDLE, all outputs cleared, pending response discarded. The pointer returns to NREQ-1.
- Arithmetic: the arbiter does not modify the product; width is exactly 2*WIDTH, sign preserved.

Test Plan:
- Single request: req0 A=10, B=20, other valids 0. Required: req_ready[0] the same cycle, mult_start one cycle later for one cycle, mult_a=10, mult_b=20. rsp_valid[0] one cycle after done with rsp_product=200, rsp_err=0. busy high from ISSUE to the handshake.
- Signed operands, four back-to-back requests on req1: (-10,20), (10,-20), (-10,-20), (0,10). Required products -200, -200, 200, 0 in order, each with its own start pulse.
- Contention:
  - All four requesters valid simultaneously from reset, with operands (i+1, 3) for requester i. Required grant order 0,1,2,3 and products 3,6,9,12 each on the correct rsp_valid bit.
  - Then req0 and req2 re-request while req2's response is pending. Next grant order is 0 before 2, because last=3.
- Backpressure: hold rsp_ready[1] low for 20 cycles after rsp_valid[1]. Required: rsp_valid and rsp_product stable throughout, req_ready stays 0 for all requesters, and IDLE is entered the cycle after rsp_ready[1] rises.
- Timeout: multiplier stub never asserts done, TIMEOUT=10. Required: rsp_valid[grant]=1 with rsp_err=1 and rsp_product=0 exactly 10 cycles after BLANK entry. A stale mult_done=1 held during ISSUE/BLANK must not complete the operation.
- Reset mid-operation: assert rst for one cycle while in WAIT. Required:
  - The cycle after, every output is 0 and no rsp_valid ever appears for the aborted operation.
  - The next request (7,-6) returns -42 with requester 0 priority restored.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between NREQ requesters.
// Issues a one-cycle start, blanks a possibly stale done, and times out to an error response.
module mult_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 100
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [2*WIDTH-1:0]      rsp_product,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    mult_start,
   output logic [WIDTH-1:0]        mult_a,
   output logic [WIDTH-1:0]        mult_b,
   input  logic [2*WIDTH-1:0]      mult_product,
   input  logic                    mult_done,
   input  logic                    mult_active
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SUMW = IDXW + 1;
   localparam int CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_BLANK = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IDXW-1:0]   r_last;
   logic [IDXW-1:0]   r_grant;
   logic [IDXW-1:0]   w_win;
   logic [IDXW-1:0]   w_idx;
   logic [SUMW-1:0]   w_sum;
   logic              w_any;
   logic              w_accept;
   logic              w_done_hit;
   logic              w_timeout;
   logic [CNTW-1:0]   r_cnt;
   logic [NREQ-1:0]   w_req_ready;
   logic [NREQ-1:0]   w_grant_oh;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [2*WIDTH-1:0] r_rsp_product;
   logic              r_rsp_err;
   logic              r_busy;
   logic              r_mult_start;
   logic [WIDTH-1:0]  r_mult_a;
   logic [WIDTH-1:0]  r_mult_b;
   logic [WIDTH-1:0]  w_a_arr [NREQ];
   logic [WIDTH-1:0]  w_b_arr [NREQ];
   logic              w_unused;

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
   end

   // Multiplier activity is status only; it never steers the FSM.
   assign w_unused = mult_active;

   // First valid requester searching upward from last+1 with wrap.
   always_comb begin
      w_win = r_last;
      w_any = 1'b0;
      w_sum = '0;
      w_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_sum = {1'b0, r_last} + SUMW'(k);
         w_sum = (w_sum >= SUMW'(NREQ)) ? (w_sum - SUMW'(NREQ)) : w_sum;
         w_idx = w_sum[IDXW-1:0];
         w_win = (!w_any && req_valid[w_idx]) ? w_idx : w_win;
         w_any = w_any | req_valid[w_idx];
      end
   end

   // Accept strobe, one-hot ready, and status decodes.
   always_comb begin
      w_req_ready = '0;
      w_accept    = (r_state == S_IDLE) && w_any && !rst;
      if (w_accept) begin
         w_req_ready[w_win] = 1'b1;
      end else begin
         w_req_ready = '0;
      end
      w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
      w_done_hit = (r_state == S_WAIT) && mult_done;
      w_timeout  = (r_state == S_WAIT) && !mult_done && (r_cnt == CNTW'(TIMEOUT - 1));
   end

   // Next-state logic; done is only honoured in WAIT.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next = S_BLANK;
         S_BLANK: w_next = S_WAIT;
         S_WAIT:  w_next = (w_done_hit || w_timeout) ? S_RESP : S_WAIT;
         S_RESP:  w_next = rsp_ready[r_grant] ? S_IDLE : S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   // State, pointer, operand latch, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_last        <= IDXW'(NREQ - 1);
         r_grant       <= '0;
         r_cnt         <= '0;
         r_rsp_valid   <= '0;
         r_rsp_product <= '0;
         r_rsp_err     <= 1'b0;
         r_busy        <= 1'b0;
         r_mult_start  <= 1'b0;
         r_mult_a      <= '0;
         r_mult_b      <= '0;
      end else begin
         r_state      <= w_next;
         r_mult_start <= (w_next == S_ISSUE);
         r_busy       <= (w_next != S_IDLE);
         r_rsp_valid  <= (w_next == S_RESP) ? w_grant_oh : '0;
         r_cnt        <= ((r_state == S_BLANK) || (r_state == S_WAIT)) ? (r_cnt + CNTW'(1)) : '0;
         if (w_accept) begin
            r_mult_a <= w_a_arr[w_win];
            r_mult_b <= w_b_arr[w_win];
            r_grant  <= w_win;
            r_last   <= w_win;
         end
         // Done beats a timeout expiring in the same cycle.
         if (w_done_hit) begin
            r_rsp_product <= mult_product;
            r_rsp_err     <= 1'b0;
         end else if (w_timeout) begin
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b1;
         end
      end
   end

   assign req_ready   = w_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_product = r_rsp_product;
   assign rsp_err     = r_rsp_err;
   assign busy        = r_busy;
   assign mult_start  = r_mult_start;
   assign mult_a      = r_mult_a;
   assign mult_b      = r_mult_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter; the multiplier is stubbed by hand in the
// stimulus so done timing, stale done and timeouts are fully controlled.
module tb_mult_share_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 10;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [2*WIDTH-1:0]    rsp_product;
   logic                  rsp_err;
   logic                  busy;
   logic                  mult_start;
   logic [WIDTH-1:0]      mult_a;
   logic [WIDTH-1:0]      mult_b;
   logic [2*WIDTH-1:0]    mult_product;
   logic                  mult_done;
   logic                  mult_active;

   logic [WIDTH-1:0]      op_a [NREQ];
   logic [WIDTH-1:0]      op_b [NREQ];
   logic signed [63:0]    p;
   int                    checks = 0;
   int                    failures = 0;

   assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
   assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

   always #5 clk = ~clk;

   mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_err(rsp_err),
      .busy(busy), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_product(mult_product), .mult_done(mult_done), .mult_active(mult_active)
   );

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      op_a[i] = a;
      op_b[i] = b;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_product"}, rsp_product, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mult_start"}, mult_start, 0);
      chk({tag, "_mult_a"}, mult_a, 0);
      chk({tag, "_mult_b"}, mult_b, 0);
   endtask

   // In IDLE with the winner valid: check ready, take the handshake, land in ISSUE.
   task automatic grant_phase(input logic [3:0] g);
      #1;
      chk("req_ready_grant", req_ready, g);
      tick();
      req_valid = req_valid & ~g;
      chk("mult_start_issue", mult_start, 1);
      chk("busy_issue", busy, 1);
   endtask

   // From ISSUE: BLANK, WAIT, lat idle WAIT cycles, done, then response handshake.
   task automatic resp_phase(input logic [3:0] g, input logic signed [63:0] exp, input int lat);
      tick();
      chk("mult_start_pulse", mult_start, 0);
      tick();
      for (int i = 0; i < lat; i++) tick();
      chk("rsp_valid_before_done", rsp_valid, 0);
      p = 64'($signed(mult_a)) * 64'($signed(mult_b));
      mult_product = p;
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      chk("rsp_valid", rsp_valid, g);
      chk("rsp_product", rsp_product, exp);
      chk("rsp_err", rsp_err, 0);
      chk("req_ready_resp", req_ready, 0);
      rsp_ready = g;
      tick();
      rsp_ready = '0;
      chk("rsp_valid_clear", rsp_valid, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      mult_done = 1'b0; mult_product = '0; mult_active = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, 0, 0);
      tick(); tick();
      rst = 1'b0;
      chk_all_zero("reset");

      // Single request.
      set_op(0, 10, 20);
      req_valid = 4'b0001;
      grant_phase(4'b0001);
      chk("mult_a_latch", mult_a, 10);
      chk("mult_b_latch", mult_b, 20);
      resp_phase(4'b0001, 200, 1);

      // Signed back-to-back on requester 1.
      set_op(1, -10, 20);  req_valid = 4'b0010; grant_phase(4'b0010); resp_phase(4'b0010, -200, 0);
      set_op(1, 10, -20);  req_valid = 4'b0010; grant_phase(4'b0010); resp_phase(4'b0010, -200, 0);
      set_op(1, -10, -20); req_valid = 4'b0010; grant_phase(4'b0010); resp_phase(4'b0010, 200, 0);
      set_op(1, 0, 10);    req_valid = 4'b0010; grant_phase(4'b0010); resp_phase(4'b0010, 0, 0);

      // Contention from reset: all four valid.
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 3);
      req_valid = 4'b1111;
      tick();
      chk("req_ready_in_reset", req_ready, 0);
      chk("busy_in_reset", busy, 0);
      rst = 1'b0;
      grant_phase(4'b0001); resp_phase(4'b0001, 3, 2);
      grant_phase(4'b0010); resp_phase(4'b0010, 6, 0);
      grant_phase(4'b0100);
      set_op(0, 5, 5);
      set_op(2, -4, 3);
      req_valid = req_valid | 4'b0101;
      resp_phase(4'b0100, 9, 1);
      grant_phase(4'b1000); resp_phase(4'b1000, 12, 0);
      grant_phase(4'b0001); resp_phase(4'b0001, 25, 0);
      grant_phase(4'b0100); resp_phase(4'b0100, -12, 0);

      // Backpressure on requester 1 with requester 0 waiting.
      set_op(1, 7, 8); req_valid = 4'b0010;
      grant_phase(4'b0010);
      set_op(0, 1, -1); req_valid = 4'b0001;
      tick(); tick();
      mult_product = 64'd56; mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      rsp_ready = 4'b1101;
      for (int i = 0; i < 20; i++) begin
         chk("bp_rsp_valid", rsp_valid, 4'b0010);
         chk("bp_rsp_product", rsp_product, 56);
         chk("bp_req_ready", req_ready, 0);
         tick();
      end
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      chk("bp_rsp_valid_clear", rsp_valid, 0);
      chk("bp_busy_idle", busy, 0);
      chk("bp_idle_ready", req_ready, 4'b0001);
      grant_phase(4'b0001); resp_phase(4'b0001, -1, 0);

      // Timeout with stale done held through ISSUE and BLANK.
      set_op(3, 5, 6); req_valid = 4'b1000;
      grant_phase(4'b1000);
      mult_done = 1'b1; mult_product = 64'd99;
      tick();
      tick();
      mult_done = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk("to_no_rsp_yet", rsp_valid, 0);
         tick();
      end
      chk("to_rsp_valid", rsp_valid, 4'b1000);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_product", rsp_product, 0);
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = '0;
      chk("to_rsp_clear", rsp_valid, 0);

      // Done arriving on the last timeout cycle wins.
      set_op(3, 2, -3); req_valid = 4'b1000;
      grant_phase(4'b1000); resp_phase(4'b1000, -6, 8);

      // Reset while in WAIT.
      set_op(2, 2, 2); req_valid = 4'b0100;
      grant_phase(4'b0100);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all_zero("midreset");
      mult_done = 1'b1; mult_product = 64'd4;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midreset_no_rsp", rsp_valid, 0);
         chk("midreset_busy", busy, 0);
      end
      mult_done = 1'b0;
      set_op(0, 7, -6); set_op(3, 1, 1); req_valid = 4'b1001;
      grant_phase(4'b0001); resp_phase(4'b0001, -42, 0);
      grant_phase(4'b1000); resp_phase(4'b1000, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
